// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port among N producers.
// Define WR_ARB_STATS_EN to add per-requester accepted-word counters on grant_cnt_o.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      req_i,
    input  logic [N*DW-1:0]   data_i,
    output logic [N-1:0]      ready_o,
    output logic [N-1:0]      grant_o,
    output logic              busy_o,
    input  logic              fifo_full_i,
    output logic              fifo_wr_en_o,
    output logic [DW-1:0]     fifo_d_in_o
`ifdef WR_ARB_STATS_EN
    ,
    output logic [N*16-1:0]   grant_cnt_o
`endif
);

    localparam int OW  = (N > 1) ? $clog2(N) : 1;
    localparam int BCW = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_e          state_q;
    logic [N-1:0]    grant_q;
    logic            busy_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   rr_ptr_q;
    logic [BCW-1:0]  burst_cnt_q;

    logic [OW-1:0]   rr_ptr_d;
    logic [BCW-1:0]  burst_cnt_d;
    logic            pick_found_s;
    logic [OW-1:0]   pick_idx_s;
    logic [OW-1:0]   cand_s;
    logic            owner_req_s;
    logic            accept_s;
    logic            burst_last_s;
    logic [DW-1:0]   data_arr_s [N];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_unpack
            assign data_arr_s[g] = data_i[g*DW +: DW];
        end
    endgenerate

    // Round-robin search: first requester at or after rr_ptr_q, wrapping modulo N.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = OW'((int'(rr_ptr_q) + k) % N);
            if (!pick_found_s && req_i[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Zero-cycle write path from the owning producer to the FIFO, blocked in reset.
    always_comb begin
        owner_req_s  = req_i[owner_q];
        accept_s     = 1'b0;
        ready_o      = '0;
        fifo_wr_en_o = 1'b0;
        fifo_d_in_o  = '0;
        if (!rst_i && (state_q == ST_BURST)) begin
            accept_s     = owner_req_s & ~fifo_full_i;
            ready_o      = accept_s ? onehot(owner_q) : '0;
            fifo_wr_en_o = accept_s;
            fifo_d_in_o  = data_arr_s[owner_q];
        end else begin
            accept_s     = 1'b0;
        end
    end

    assign burst_last_s = (burst_cnt_q == BCW'(MAX_BURST - 1));
    assign burst_cnt_d  = burst_cnt_q + BCW'(1);
    assign rr_ptr_d     = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

    // Arbitration FSM; grant and busy are registered, exit always passes through IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_q     <= ST_BURST;
                        grant_q     <= onehot(pick_idx_s);
                        busy_q      <= 1'b1;
                        owner_q     <= pick_idx_s;
                        burst_cnt_q <= '0;
                    end else begin
                        state_q     <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!owner_req_s || (accept_s && burst_last_s)) begin
                        state_q     <= ST_IDLE;
                        grant_q     <= '0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                    end else if (accept_s) begin
                        burst_cnt_q <= burst_cnt_d;
                    end else begin
                        burst_cnt_q <= burst_cnt_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;

`ifdef WR_ARB_STATS_EN
    logic [15:0] stat_cnt_q [N];

    generate
        for (g = 0; g < N; g++) begin : g_stats
            // Saturating count of words accepted from requester g.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    stat_cnt_q[g] <= 16'h0000;
                end else if (accept_s && (owner_q == OW'(g)) && (stat_cnt_q[g] != 16'hFFFF)) begin
                    stat_cnt_q[g] <= stat_cnt_q[g] + 16'h0001;
                end else begin
                    stat_cnt_q[g] <= stat_cnt_q[g];
                end
            end
            assign grant_cnt_o[g*16 +: 16] = stat_cnt_q[g];
        end
    endgenerate
`endif

endmodule
